// File: rtl/mips_debug_pkg.sv
// Shared encodings for the MIPS run/step/halt debug controller.
package mips_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_HALT = 2'b11
  } cmd_e;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

endpackage

// File: rtl/mips_debug_if.sv
// Host command handshake for the debug controller: strobe, command code, ready.
interface mips_debug_if;
  import mips_debug_pkg::*;

  logic i_cmd_valid;
  cmd_e i_cmd;
  logic o_cmd_ready;

  modport master (output i_cmd_valid, output i_cmd, input  o_cmd_ready);
  modport slave  (input  i_cmd_valid, input  i_cmd, output o_cmd_ready);

endinterface

// File: rtl/debug_snapshot_reg.sv
// Snapshot register for all inter-stage latch buses plus a registered
// word-select readback mux (out-of-range selects read as zero).
module debug_snapshot_reg #(
  parameter int LEN       = 32,
  parameter int NB_STAGES = 4,
  parameter int NB_LATCH  = 192,
  localparam int NB_WORDS = NB_LATCH / LEN,
  localparam int SW       = (NB_STAGES > 1) ? $clog2(NB_STAGES) : 1,
  localparam int WW       = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_load,
  input  logic [NB_STAGES*NB_LATCH-1:0] i_data,
  input  logic [SW-1:0]                 i_rd_stage,
  input  logic [WW-1:0]                 i_rd_word,
  output logic [LEN-1:0]                o_rd_data
);

  logic [NB_STAGES*NB_LATCH-1:0] snap_q;
  logic [LEN-1:0]                words [NB_STAGES][NB_WORDS];

  // NOTE: the snapshot is a flop bank, not a RAM, so it can take the async
  // reset; host readback right after reset must see zeros, not stale data.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      snap_q <= '0;
    else if (i_load) snap_q <= i_data;
  end

  for (genvar s = 0; s < NB_STAGES; s++) begin : g_stage
    for (genvar w = 0; w < NB_WORDS; w++) begin : g_word
      assign words[s][w] = snap_q[s*NB_LATCH + w*LEN +: LEN];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_rd_data <= '0;
    end else if (int'(i_rd_stage) < NB_STAGES && int'(i_rd_word) < NB_WORDS) begin
      o_rd_data <= words[i_rd_stage][i_rd_word];
    end else begin
      o_rd_data <= '0;
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Run/step/halt controller beside the MIPS pipeline: advance enable, cycle
// counter, halt-opcode detect, latch snapshot. Optional MIPS_DEBUG_BREAKPOINT_EN.
module mips_debug_ctrl
  import mips_debug_pkg::*;
#(
  parameter int LEN            = 32,
  parameter int NB_STAGES      = 4,
  parameter int NB_LATCH       = 192,
  parameter int NB_CYCLES      = 32,
  parameter int NB_INSTRUCCION = 6,
  parameter logic [NB_INSTRUCCION-1:0] HALT_OPCODE = NB_INSTRUCCION'(HALT_OPCODE_DEFAULT),
  localparam int NB_WORDS      = NB_LATCH / LEN,
  localparam int SW            = (NB_STAGES > 1) ? $clog2(NB_STAGES) : 1,
  localparam int WW            = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  mips_debug_if.slave                   cmd_if,
`ifdef MIPS_DEBUG_BREAKPOINT_EN
  input  logic                          i_bp_en,
  input  logic [LEN-1:0]                i_bp_pc,
  input  logic [LEN-1:0]                i_if_pc,
`endif
  input  logic                          i_wb_valid,
  input  logic [NB_INSTRUCCION-1:0]     i_wb_opcode,
  input  logic [NB_STAGES*NB_LATCH-1:0] i_latches,
  output logic                          o_pipe_en,
  output logic [1:0]                    o_state,
  output logic [NB_CYCLES-1:0]          o_cycle_count,
  input  logic [SW-1:0]                 i_rd_stage,
  input  logic [WW-1:0]                 i_rd_word,
  output logic [LEN-1:0]                o_rd_data
);

  state_e state_q;
  logic   pipe_en_d;
  logic   halt_op;
  logic   cmd_acc;
  logic   bp_hit;

  assign halt_op = i_wb_valid && (i_wb_opcode == HALT_OPCODE);
  assign cmd_acc = cmd_if.i_cmd_valid && cmd_if.o_cmd_ready;

`ifdef MIPS_DEBUG_BREAKPOINT_EN
  // Only RUN honours breakpoints, so a STEP can move off a matching PC.
  assign bp_hit = (state_q == ST_RUN) && i_bp_en && (i_if_pc == i_bp_pc);
`else
  assign bp_hit = 1'b0;
`endif

  assign cmd_if.o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign o_pipe_en          = ((state_q == ST_RUN) && !bp_hit) || (state_q == ST_STEP);
  assign o_state            = state_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_acc && cmd_if.i_cmd == CMD_RUN)       state_q <= ST_RUN;
          else if (cmd_acc && cmd_if.i_cmd == CMD_STEP) state_q <= ST_STEP;
        end
        ST_RUN: begin
          // Halt opcode outranks both the breakpoint and a host halt.
          if (halt_op)                                  state_q <= ST_DONE;
          else if (bp_hit)                              state_q <= ST_IDLE;
          else if (cmd_acc && cmd_if.i_cmd == CMD_HALT) state_q <= ST_IDLE;
        end
        ST_STEP: state_q <= halt_op ? ST_DONE : ST_IDLE;
        ST_DONE: state_q <= ST_DONE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_cycle_count <= '0;
      pipe_en_d     <= 1'b0;
    end else begin
      pipe_en_d <= o_pipe_en;
      if (o_pipe_en && o_cycle_count != '1) o_cycle_count <= o_cycle_count + 1'b1;
    end
  end

  // Loading one edge behind the enable captures the latches as they stand
  // after each advancing edge, including the last one.
  debug_snapshot_reg #(
    .LEN       (LEN),
    .NB_STAGES (NB_STAGES),
    .NB_LATCH  (NB_LATCH)
  ) u_snapshot (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (pipe_en_d),
    .i_data     (i_latches),
    .i_rd_stage (i_rd_stage),
    .i_rd_word  (i_rd_word),
    .o_rd_data  (o_rd_data)
  );

endmodule

// File: doc/mips_debug_ctrl.md
# mips_debug_ctrl

Run/step/halt controller for the 5-stage MIPS pipeline, instantiated beside the pipeline top-level.
- Gates a single pipeline-advance enable.
- Counts executed cycles.
- Detects the program-halt opcode at write-back.
- Snapshots all inter-stage latch buses into a word-addressable buffer for host readback.
- Generalises the fixed four-latch debug outputs to NB_STAGES latches of configurable width.

## Interface
- LEN, 32, data word width; readback granularity
- NB_STAGES, 4, number of inter-stage latches observed
- NB_LATCH, 192, bits per latch slot; narrower latches zero-extended by the top; must be a multiple of LEN
- NB_CYCLES, 32, cycle-counter width
- NB_INSTRUCCION, 6, opcode width
- HALT_OPCODE, 6'b111111, opcode that ends the program
- i_clk  in  1  clock; all state on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command strobe
- i_cmd  in  2  00 nop, 01 run, 10 step, 11 halt
- o_cmd_ready  out  1  command may be accepted this cycle
- i_wb_valid  in  1  write-back stage holds a real instruction
- i_wb_opcode  in  NB_INSTRUCCION  opcode in write-back
- i_latches  in  NB_STAGES*NB_LATCH  concatenated latch buses, stage 0 in LSBs
- o_pipe_en  out  1  pipeline advances on this edge
- o_state  out  2  current FSM state
- o_cycle_count  out  NB_CYCLES  advancing cycles since reset
- i_rd_stage  in  clog2(NB_STAGES)  snapshot stage select
- i_rd_word  in  clog2(NB_LATCH/LEN)  word within stage
- o_rd_data  out  LEN  selected snapshot word

## Operation
- **States:**
  - IDLE=0: paused, o_pipe_en=0
  - RUN=1: o_pipe_en=1
  - STEP=2: o_pipe_en=1 for exactly one cycle
  - DONE=3: o_pipe_en=0, sticky until reset
- **Command acceptance:** a command is accepted when i_cmd_valid && o_cmd_ready. o_cmd_ready=1 in IDLE and RUN, 0 in STEP and DONE.
- **IDLE:**
  - run -> RUN
  - step -> STEP
  - halt/nop -> stay
- **RUN:**
  - halt cmd -> IDLE
  - run/step accepted, no effect
  - i_wb_valid && i_wb_opcode==HALT_OPCODE -> DONE
  - Halt cmd and halt opcode in the same cycle: DONE wins.
- **STEP:**
  - Always leaves after one cycle: to DONE if halt opcode seen that cycle, else IDLE.
- **Cycle counter:** increments on every edge with o_pipe_en=1. Saturates at all-ones, never wraps.
- **Snapshot:**
  - Registered flag pipe_en_d = o_pipe_en delayed one cycle.
  - On every edge with pipe_en_d=1, snapshot loads i_latches. The last load therefore holds latch contents after the final advancing edge.
  - Snapshot is not loaded while paused.
- **Readback:**
  - o_rd_data registered: word i_rd_word of stage i_rd_stage.
  - Out-of-range stage or word returns 0.

## Timing
- **Reset values:** state IDLE, o_pipe_en=0, o_cmd_ready=1, o_cycle_count=0, snapshot all-zero, o_rd_data=0, pipe_en_d=0.
- **Command to enable:** command accepted at edge N -> o_pipe_en=1 during cycle N+1.
- **Halt response:** halt accepted at edge N -> o_pipe_en=0 from cycle N+1; no further advance.
- **Halt opcode:** when the halt opcode is sampled while o_pipe_en=1 at edge N, that edge still advances the pipeline; o_pipe_en=0 from cycle N+1.
- **Snapshot:** final snapshot stable one edge after o_pipe_en falls.
- **Readback latency:** 1 cycle from select to o_rd_data.
- **Reset mid-run:** reset asserted mid-RUN/STEP forces all reset values immediately (asynchronous); snapshot contents lost.

## Configuration
- **MIPS_DEBUG_BREAKPOINT_EN defined:**
  - Adds ports i_bp_en (1), i_bp_pc (LEN), i_if_pc (LEN).
  - In RUN, i_bp_en && i_if_pc==i_bp_pc -> IDLE. The matching fetch edge does not advance: o_pipe_en is combinationally 0 that cycle.
  - Halt opcode has priority over breakpoint.
  - Breakpoint not checked in STEP, so stepping off a breakpoint works.
- **Undefined:** ports absent, no PC comparison logic.

## Structure
- **Shared package mips_debug_pkg:**
  - State encodings IDLE/RUN/STEP/DONE
  - Command encodings
  - Default HALT_OPCODE
- **Sub-module debug_snapshot_reg:**
  - Holds NB_STAGES*NB_LATCH bits with load enable.
  - Provides the registered word-select read mux.
- **Top of block:** FSM, counter, command handshake, breakpoint compare.

## Test plan
- **Reset:** reset low 3 cycles, release -> state 0, o_pipe_en=0, o_cycle_count=0, o_rd_data=0.
- **Step:** 3 step commands spaced 4 cycles apart -> o_pipe_en pulses exactly 3 single cycles, o_cycle_count=3, o_cmd_ready=0 only on pulse cycles.
- **Run then halt:** run, wait 10 cycles, halt cmd -> o_cycle_count=10 or 11 per the command-to-enable/halt-response rules, state IDLE. Stage 2 word 0 of snapshot equals i_latches value present after the last advance.
- **Halt opcode:** in RUN, drive i_wb_valid=1, i_wb_opcode=6'h3F together with halt cmd -> state DONE next cycle, further run commands ignored (o_cmd_ready=0).
- **Counter saturation and readback range:** NB_CYCLES=4, run 20 cycles -> o_cycle_count=15. Read i_rd_word beyond range -> 0.
- **Breakpoint (macro defined):** i_bp_pc=32'h0000_0010, i_if_pc ramps by 4 -> state IDLE when i_if_pc=0x10, no advance that cycle. Step then proceeds to 0x14.
